// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel: default sizing, state encoding, duty clamp.
package pwm_pkg;

    localparam int unsigned PERIOD_TICKS_DEF = 20000;
    localparam int unsigned CNT_W_DEF        = 15;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_t;

    // Saturate a requested duty at the frame length (100 %).
    function automatic logic [31:0] clamp_duty(input logic [31:0] value, input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm_channel_if.sv
// Duty-load handshake between a duty source and a PWM channel.
interface pwm_channel_if
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic [CNT_W-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );

endinterface

// File: rtl/tick_sync.sv
// Brings the divider's 1 MHz level into the clk domain and emits a one-clk pulse per rising edge.
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_1MHz,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Two-flop synchroniser followed by one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= clk_1MHz;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

endmodule

// File: rtl/pwm_channel.sv
// Single PWM channel on a 1 us timebase; new duty values take effect only at frame boundaries.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD_TICKS = PERIOD_TICKS_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_1MHz,
    input  logic             enable,
    pwm_channel_if.slave     duty_bus,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_active
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_TICKS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_q;
    logic             pending_d;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] shadow_d;
    logic [CNT_W-1:0] duty_active_d;
    logic             period_start_d;
    logic             pwm_d;
    logic             commit;
    logic             xfer;
    logic             tick;

    tick_sync u_tick_sync (
        .clk      (clk),
        .rst      (rst),
        .clk_1MHz (clk_1MHz),
        .tick     (tick)
    );

    assign duty_bus.duty_ready = ~pending_q;
    assign xfer                = duty_bus.duty_valid & ~pending_q;

    // Frame sequencing: counter, frame-start pulse and commit point for the shadow duty.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_start_d = 1'b0;
        commit         = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                commit = pending_q;
                if (enable) begin
                    state_d        = S_RUN;
                    period_start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d          = '0;
                        period_start_d = 1'b1;
                        commit         = pending_q;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow register: a transfer can only land while nothing is pending, so it never races a commit.
    always_comb begin
        pending_d     = pending_q;
        shadow_d      = shadow_q;
        duty_active_d = duty_active;
        if (commit) begin
            duty_active_d = shadow_q;
            pending_d     = 1'b0;
        end
        if (xfer) begin
            pending_d = 1'b1;
            shadow_d  = CNT_W'(clamp_duty(32'(duty_bus.duty_in), 32'(PERIOD_TICKS)));
        end
    end

    assign pwm_d = (state_q == S_RUN) && (cnt_q < duty_active);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            duty_active  <= '0;
            period_start <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            duty_active  <= duty_active_d;
            period_start <= period_start_d;
            pwm_out      <= pwm_d;
        end
    end

endmodule

// File: doc/pwm_channel.md
Name: pwm_channel

Overview:
- Single-channel PWM generator, directly downstream of the clock divider block `clks`.
- Consumes the divider's `clk_1MHz` square-wave output as a 1 µs timebase and produces one PWM waveform.
- Default frame is 20 ms (50 Hz, servo-class), with a 1 µs duty resolution.
- Duty is loaded through a valid/ready handshake into a shadow register and committed only at a period boundary, so the output never glitches mid-frame.

Parameters:
- PERIOD_TICKS, 20000, timebase ticks per PWM frame (20000 × 1 µs = 20 ms).
- CNT_W, 15, width of the tick counter and of all duty values; must satisfy 2^CNT_W > PERIOD_TICKS.

Ports:
- clk  in  1  system clock; same clock that drives `clks`.
- rst  in  1  synchronous, active-high reset.
- clk_1MHz  in  1  1 MHz level from `clks`; treated as data and sampled on clk.
- enable  in  1  1 = run, 0 = idle with output held low.
- duty_in  in  CNT_W  requested high time, in ticks.
- duty_valid  in  1  duty_in is valid this cycle.
- duty_ready  out  1  channel can accept a new duty value.
- pwm_out  out  1  PWM output (registered).
- period_start  out  1  one-clk pulse at the start of each frame.
- duty_active  out  CNT_W  duty value currently in effect.

Behaviour:
- All state changes on the rising edge of clk. rst has priority over every other input.
- Reset values:
  - counter cnt = 0; state = IDLE.
  - pwm_out = 0; period_start = 0; duty_active = 0.
  - pending flag = 0, so duty_ready = 1.
  - Any pending duty value is discarded.
- Tick generation:
  - clk_1MHz passes through a 2-FF synchroniser, then a third register for edge detection.
  - tick = synchronised rising edge, exactly one clk wide.
  - Latency from the clk_1MHz edge to tick is 2–3 clk cycles.
  - tick is ignored while in IDLE.
- State machine:
  - IDLE:
    - cnt = 0 and pwm_out = 0.
    - A pending duty value commits to duty_active on the next clk.
    - enable = 1 → go to RUN; period_start pulses in that same transition cycle.
  - RUN, on each tick:
    - cnt = PERIOD_TICKS-1 → cnt wraps to 0, period_start = 1 for that clk, and any pending duty commits to duty_active.
    - Otherwise cnt increments by 1.
  - RUN, enable = 0 → go to IDLE on the next clk, cnt = 0, pwm_out = 0. Leaving mid-frame truncates the frame; there is no drain.
- Output:
  - In RUN, pwm_out is registered as (cnt < duty_active), with one clk of latency after cnt changes.
  - duty_active = 0 → constant low.
  - duty_active = PERIOD_TICKS → constant high.
- Handshake:
  - duty_ready = ~pending (combinational).
  - Transfer occurs when duty_valid & duty_ready.
  - On transfer: pending value = min(duty_in, PERIOD_TICKS), and pending is set.
  - duty_valid while duty_ready = 0 is ignored; the source must hold its value.
- Boundary conditions:
  - Transfer and wrap in the same clk: the wrap finds no pending value (ready was 1), so the new value commits at the next wrap, one frame later.
  - duty_in ≥ PERIOD_TICKS: clamped to PERIOD_TICKS (100 %).
  - rst asserted mid-frame: next clk returns to reset values. pwm_out falls within 1 clk.

Decomposition:
- Package pwm_pkg holds:
  - PERIOD_TICKS and CNT_W defaults.
  - State encoding localparams ST_IDLE and ST_RUN.
  - Clamp helper function.
- Sub-module tick_sync (ports: clk, rst, clk_1MHz, tick) holds the synchroniser and edge detector. It is reused by future channels.
- pwm_channel contains the FSM, counter, shadow register and compare.

Test Plan:
- Common setup:
  - clk period 40 ns.
  - Bench drives clk_1MHz as a 1000 ns square wave.
  - PERIOD_TICKS = 20 unless stated.
- Reset with clk_1MHz toggling, then release with enable = 0:
  - pwm_out = 0, period_start never pulses, duty_ready = 1, duty_active = 0.
- Load duty 5 in IDLE, set enable:
  - duty_active = 5 after 1 clk; one period_start pulse on entry.
  - pwm_out high for exactly 5 ticks (5 µs) of every 20-tick frame.
  - period_start spacing is 20 µs.
- In RUN with duty 5, transfer 12 mid-frame:
  - duty_ready drops for the rest of the frame.
  - Current frame keeps 5 µs high; next frame 12 µs; duty_ready returns to 1 on the wrap.
- Extremes and clamp:
  - Duty 0 → pwm_out constantly 0.
  - Duty 20 → constantly 1.
  - duty_in = 500 → duty_active = 20.
- Force a transfer in the exact clk of a wrap:
  - New value is applied only at the following period_start (one frame later).
- Boundary drop and reset:
  - Drop enable at cnt = 3 with duty 10 → pwm_out low within 2 clk, cnt = 0.
  - Assert rst mid-frame with a value pending → duty_active = 0, duty_ready = 1, pending value lost.
- Default parameters (PERIOD_TICKS = 20000), duty 1500:
  - 20 ms frame with a 1.5 ms high pulse, within ±1 clk.
